// File: rtl/spectro_pkg.sv
// Shared definitions for the spectrometer reader side: default geometry and the
// capture FSM state encoding (also used by the main sensor FSM).
package spectro_pkg;

    localparam int unsigned NPIX_DEF     = 288;
    localparam int unsigned ADC_BITS_DEF = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        CONV  = 3'd2,
        ACC   = 3'd3,
        WAITL = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/line_ram.sv
// Line buffer: one write port, two registered read ports (consumer and accumulator).
// Storage is not reset so it maps onto block RAM; only the read registers reset.
module line_ram #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra_a,
    output logic [DW-1:0] rd_a,
    input  logic [AW-1:0] ra_b,
    output logic [DW-1:0] rd_b
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_a_d, rd_a_q;
    logic [DW-1:0] rd_b_d, rd_b_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd_a_d = mem[ra_a];
        rd_b_d = mem[ra_b];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign rd_a = rd_a_q;
    assign rd_b = rd_b_q;

endmodule

// File: rtl/spectro_line_capture.sv
// Captures one ADC sample per sensor TRG edge and sums 2**AVG_LOG2 lines into a
// line buffer that is frozen and readable once the average is complete.
module spectro_line_capture
    import spectro_pkg::*;
#(
    parameter int unsigned NPIX       = NPIX_DEF,
    parameter int unsigned ADC_BITS   = ADC_BITS_DEF,
    parameter int unsigned AVG_LOG2   = 2,
    parameter int unsigned SAMPLE_DLY = 3,
    parameter int unsigned AW         = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         trg_in,
    output logic                         adc_conv,
    input  logic [ADC_BITS-1:0]          adc_data,
    input  logic [AW-1:0]                rd_addr,
    output logic [ADC_BITS+AVG_LOG2-1:0] rd_data,
    output logic                         ready,
    input  logic                         ack,
    output logic                         err,
    output logic                         busy
);

    localparam int unsigned SW = ADC_BITS + AVG_LOG2;
    localparam int unsigned LW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned CW = $clog2(SAMPLE_DLY + 1);
    localparam logic [LW-1:0] LAST_LINE = LW'((2 ** AVG_LOG2) - 1);
    localparam logic [AW-1:0] LAST_PIX  = AW'(NPIX - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SAMPLE_DLY);

    state_e        state_q, state_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sum_q, sum_d;
    logic          conv_q, conv_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          trg_s1_q, trg_s1_d;
    logic          trg_s2_q, trg_s2_d;
    logic          trg_prev_q, trg_prev_d;
    logic          edge_c;
    logic          wr_en_c;
    logic [SW-1:0] acc_rd;

    line_ram #(
        .AW (AW),
        .DW (SW)
    ) u_line_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en_c),
        .wa    (pix_q),
        .wd    (sum_q),
        .ra_a  (rd_addr),
        .rd_a  (rd_data),
        .ra_b  (pix_q),
        .rd_b  (acc_rd)
    );

    assign edge_c = trg_s2_q & ~trg_prev_q;

    // Next-state and output logic; start aborts an in-flight pixel and rewinds the line.
    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        conv_d     = 1'b0;
        err_d      = err_q;
        wr_en_c    = 1'b0;
        trg_s1_d   = trg_in;
        trg_s2_d   = trg_s1_q;
        trg_prev_d = trg_s2_q;

        if (ack) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                    pix_d   = '0;
                    line_d  = '0;
                end
            end
            ARMED: begin
                if (start) begin
                    pix_d = '0;
                    if (pix_q != '0) begin
                        err_d = 1'b1;
                    end
                end else if (edge_c) begin
                    conv_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (edge_c) begin
                    err_d = 1'b1;
                end
                if (start) begin
                    state_d = ARMED;
                    pix_d   = '0;
                    if (pix_q != '0) begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    sum_d   = SW'(adc_data) + ((line_q == '0) ? SW'(0) : acc_rd);
                    state_d = ACC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACC: begin
                if (edge_c) begin
                    err_d = 1'b1;
                end
                if (start) begin
                    state_d = ARMED;
                    pix_d   = '0;
                    if (pix_q != '0) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wr_en_c = 1'b1;
                    if (pix_q == LAST_PIX) begin
                        pix_d = '0;
                        if (line_q == LAST_LINE) begin
                            state_d = DONE;
                        end else begin
                            line_d  = line_q + LW'(1);
                            state_d = WAITL;
                        end
                    end else begin
                        pix_d   = pix_q + AW'(1);
                        state_d = ARMED;
                    end
                end
            end
            WAITL: begin
                if (start) begin
                    state_d = ARMED;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pix_q      <= '0;
            line_q     <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            conv_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            trg_s1_q   <= 1'b0;
            trg_s2_q   <= 1'b0;
            trg_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            conv_q     <= conv_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            trg_s1_q   <= trg_s1_d;
            trg_s2_q   <= trg_s2_d;
            trg_prev_q <= trg_prev_d;
        end
    end

    assign adc_conv = conv_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spectro_line_capture.sv
// Drives one averaging (AVG_LOG2=2) and one non-averaging (AVG_LOG2=0) capture block
// from the same stimulus and checks buffer contents against a bench-side model.
module tb_spectro_line_capture;

    localparam int NPIX = 288;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        trg_in;
    logic [11:0] adc_data;
    logic [8:0]  rd_addr;
    logic        ack;

    logic        conv2, ready2, err2, busy2;
    logic [13:0] rdd2;
    logic        conv0, ready0, err0, busy0;
    logic [11:0] rdd0;

    logic [13:0] exp_mem [NPIX];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spectro_line_capture #(.AVG_LOG2(2)) u_dut (
        .clk(clk), .reset(reset), .start(start), .trg_in(trg_in), .adc_conv(conv2),
        .adc_data(adc_data), .rd_addr(rd_addr), .rd_data(rdd2), .ready(ready2),
        .ack(ack), .err(err2), .busy(busy2)
    );

    spectro_line_capture #(.AVG_LOG2(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .trg_in(trg_in), .adc_conv(conv0),
        .adc_data(adc_data), .rd_addr(rd_addr), .rd_data(rdd0), .ready(ready0),
        .ack(ack), .err(err0), .busy(busy0)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; trg_in = 1'b0; ack = 1'b0;
        adc_data = '0; rd_addr = '0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0; tick(1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(1); ack = 1'b0;
    endtask

    task automatic send_pix(input logic [11:0] v);
        adc_data = v;
        trg_in = 1'b1; tick(3);
        trg_in = 1'b0; tick(7);
    endtask

    task automatic wait_ready(input bit avg, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((avg ? ready2 : ready0) === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick(1);
        end
    endtask

    // Read the whole buffer back; expectation queued with each address, popped one cycle later.
    task automatic read_check(input bit avg, input string tag);
        logic [13:0] q[$];
        logic [13:0] got, exp;
        for (int a = 0; a <= NPIX; a++) begin
            if (a > 0) begin
                got = avg ? rdd2 : {2'b00, rdd0};
                exp = q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s addr %0d got %h exp %h", tag, a - 1, got, exp);
                end
            end
            if (a < NPIX) begin
                rd_addr = 9'(a);
                q.push_back(exp_mem[a]);
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; trg_in = 1'b0; ack = 1'b0;
        adc_data = '0; rd_addr = '0;
        tick(2);
        checks++;
        if ({conv0, ready0, err0, busy0, conv2, ready2, err2, busy2} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000000",
                     {conv0, ready0, err0, busy0, conv2, ready2, err2, busy2});
        end
        checks++;
        if (rdd0 !== 12'h000 || rdd2 !== 14'h0000) begin
            errors++;
            $display("FAIL reset_rd_data got %h/%h exp 0/0", rdd0, rdd2);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_single_line();
        bit ok;
        do_reset();
        pulse_start();
        for (int k = 0; k < NPIX; k++) begin
            exp_mem[k] = 14'(k);
            send_pix(12'(k));
        end
        wait_ready(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_ready got 0 exp 1"); end
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err0); end
        checks++;
        if (ready2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL avg_waitl got ready=%b busy=%b exp ready=0 busy=1", ready2, busy2);
        end
        read_check(1'b0, "single_buf");
        pulse_ack();
        checks++;
        if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got ready=%b busy=%b exp 0 0", ready0, busy0);
        end
    endtask

    task automatic test_average();
        bit ok;
        do_reset();
        for (int l = 0; l < 4; l++) begin
            pulse_start();
            for (int k = 0; k < NPIX; k++) begin
                exp_mem[k] = (l == 0) ? 14'h0FFF : exp_mem[k] + 14'h0FFF;
                send_pix(12'hFFF);
            end
            if (l < 3) begin
                tick(10);
                checks++;
                if (ready2 !== 1'b0) begin
                    errors++;
                    $display("FAIL avg_early_ready line %0d got %b exp 0", l, ready2);
                end
            end
        end
        wait_ready(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL avg_ready got 0 exp 1"); end
        checks++;
        if (err2 !== 1'b0) begin errors++; $display("FAIL avg_err got %b exp 0", err2); end
        read_check(1'b1, "avg_buf");
    endtask

    task automatic test_drop();
        bit ok;
        do_reset();
        pulse_start();
        adc_data = 12'h0AA;
        exp_mem[0] = 14'h00AA;
        trg_in = 1'b1; tick(1); trg_in = 1'b0; tick(2);
        trg_in = 1'b1; tick(1); trg_in = 1'b0; tick(8);
        checks++;
        if (err0 !== 1'b1 || err2 !== 1'b1) begin
            errors++;
            $display("FAIL drop_err got %b/%b exp 1/1", err0, err2);
        end
        for (int k = 1; k < NPIX - 1; k++) begin
            exp_mem[k] = 14'(k);
            send_pix(12'(k));
        end
        tick(10);
        checks++;
        if (ready0 !== 1'b0) begin errors++; $display("FAIL drop_ready_early got %b exp 0", ready0); end
        exp_mem[NPIX-1] = 14'(NPIX - 1);
        send_pix(12'(NPIX - 1));
        wait_ready(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drop_ready got 0 exp 1"); end
        read_check(1'b0, "drop_buf");
    endtask

    task automatic test_short_line();
        bit ok;
        do_reset();
        pulse_start();
        for (int k = 0; k < 100; k++) send_pix(12'h100 + 12'(k));
        pulse_start();
        checks++;
        if (err0 !== 1'b1 || err2 !== 1'b1) begin
            errors++;
            $display("FAIL short_err got %b/%b exp 1/1", err0, err2);
        end
        for (int k = 0; k < NPIX; k++) begin
            exp_mem[k] = 14'(k * 3);
            send_pix(12'(k * 3));
        end
        wait_ready(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL short_ready got 0 exp 1"); end
        read_check(1'b0, "short_buf");
    endtask

    task automatic test_done();
        bit ok;
        do_reset();
        pulse_start();
        for (int k = 0; k < NPIX; k++) begin
            exp_mem[k] = {2'b00, 12'hA00 ^ 12'(k)};
            send_pix(12'hA00 ^ 12'(k));
        end
        wait_ready(1'b0, ok);
        checks++;
        if (!ok || err0 !== 1'b0) begin
            errors++;
            $display("FAIL done_entry got ready=%b err=%b exp 1 0", ok, err0);
        end
        send_pix(12'h555);
        send_pix(12'h555);
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL done_trg_err got %b exp 0", err0); end
        pulse_start();
        checks++;
        if (err0 !== 1'b1 || ready0 !== 1'b1) begin
            errors++;
            $display("FAIL done_start got err=%b ready=%b exp 1 1", err0, ready0);
        end
        read_check(1'b0, "done_frozen");
        pulse_ack();
        checks++;
        if (ready0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL done_ack got ready=%b err=%b busy=%b exp 0 0 0", ready0, err0, busy0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        do_reset();
        pulse_start();
        adc_data = 12'hFFF;
        trg_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (conv0 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_conv_seen got 0 exp 1"); end
        reset = 1'b1;
        trg_in = 1'b0;
        #1;
        checks++;
        if ({conv0, ready0, busy0, conv2, ready2, busy2} !== 6'b000000) begin
            errors++;
            $display("FAIL mid_reset got %b exp 000000", {conv0, ready0, busy0, conv2, ready2, busy2});
        end
        tick(1);
        reset = 1'b0;
        tick(2);
        pulse_start();
        for (int k = 0; k < NPIX; k++) begin
            exp_mem[k] = 14'(12'h7FF - 12'(k));
            send_pix(12'h7FF - 12'(k));
        end
        wait_ready(1'b0, ok);
        checks++;
        if (!ok || err0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame got ready=%b err=%b exp 1 0", ok, err0);
        end
        read_check(1'b0, "mid_buf");
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_average();
        test_drop();
        test_short_line();
        test_done();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
